gpr_wb_arb: RTL and testbench
=============================

Name: gpr_wb_arb

Overview:
- Writeback arbiter driving the single GPR file write port (`waddr`/`wdata`/`wen`).
- Collects results from the EXU and LSU through valid/ready handshakes, plus a debug write port.
- Arbitrates among them, registers the winning write for one cycle, and exposes a forwarding lookup so the decode-stage read can see a write not yet committed to the GPR array.
- Keeps a retired-write counter for the perf/difftest hooks.

Parameters:
- `XLEN`, 32, data width of GPR values.
- `AW`, 5, GPR index width (32 registers).
- `CNTW`, 32, width of the retired-write counter.

Ports:
- `clk`  input  1  system clock, all state on rising edge
- `rst_n`  input  1  asynchronous active-low reset
- `exu_valid`  input  1  EXU result valid
- `exu_ready`  output  1  EXU result accepted this cycle
- `exu_rd`  input  AW  EXU destination register
- `exu_data`  input  XLEN  EXU result
- `lsu_valid`  input  1  LSU load result valid
- `lsu_ready`  output  1  LSU result accepted this cycle
- `lsu_rd`  input  AW  LSU destination register
- `lsu_data`  input  XLEN  load data
- `dbg_wen`  input  1  debug write request (no handshake, always wins)
- `dbg_waddr`  input  AW  debug write index
- `dbg_wdata`  input  XLEN  debug write data
- `waddr`  output  AW  to GPR write index
- `wdata`  output  XLEN  to GPR write data
- `wen`  output  1  to GPR write enable
- `fwd_raddr`  input  AW  lookup index from decode read port
- `fwd_hit`  output  1  pending write matches `fwd_raddr`
- `fwd_data`  output  XLEN  data of matching pending write
- `wb_cnt`  output  CNTW  number of committed GPR writes

Behaviour:

Reset (asynchronous on `rst_n` low, takes effect immediately):
- `wen`=0, `waddr`=0, `wdata`=0, `wb_cnt`=0.
- Round-robin pointer `last_grant`=EXU, so LSU has priority first.

Arbitration (combinational, each cycle):
- `dbg_wen`=1: `exu_ready`=`lsu_ready`=0; debug write is selected.
- Else, only one source valid: that source gets ready=1.
- Else, both valid: grant the source not equal to `last_grant`. Update `last_grant` to the winner on the clock edge.
- Ready never asserts without the matching valid. Ready is never asserted for both sources in the same cycle.
- A source holding valid must keep `rd`/`data` stable until ready. The bench checks this; the block does not.

Output register (1-cycle latency):
- On the edge after a handshake or debug request, `wen`/`waddr`/`wdata` present the selected write for exactly one cycle. The GPR array captures it on the following edge.
- Total: a result accepted in cycle N is in the GPR array after the edge ending cycle N+1.
- Destination 0: the handshake completes normally (ready=1) but the registered `wen`=0. `x0` is never written, including by debug.
- No request in a cycle: `wen`=0 next cycle; `waddr`/`wdata` hold their last value.
- Throughput: one write per cycle. There is no backpressure from the GPR side.

Forwarding (combinational):
- `fwd_hit` = `wen` && (`waddr` == `fwd_raddr`) && (`fwd_raddr` != 0).
- `fwd_data` = `wdata` when `fwd_hit`, else 0.
- This covers the one-cycle window where the write sits in the output register but the GPR array still holds the old value.

Counter:
- `wb_cnt` increments by 1 on every edge where registered `wen`=1, i.e. writes with rd=0 are not counted.
- Wraps modulo 2^CNTW with no saturation.

Simultaneous events:
- Debug plus both sources: debug wins, `last_grant` is unchanged, both sources stall.
- Reset mid-write: the pending `wen` is dropped; the GPR array is not written.
- After reset deasserts, the first arbitration follows the reset pointer.

Test Plan:
- Single EXU write: `exu_valid`=1, `exu_rd`=5, `exu_data`=0xDEADBEEF in cycle 0 -> `exu_ready`=1 in cycle 0; `wen`=1, `waddr`=5, `wdata`=0xDEADBEEF in cycle 1; `wb_cnt`=1 in cycle 2; a GPR read of x5 returns 0xDEADBEEF from cycle 2.
- Round-robin contention: both valid for 4 cycles with new data each grant (exu rd=1, lsu rd=2) -> grants LSU, EXU, LSU, EXU after reset; `waddr` sequence 2,1,2,1; `wb_cnt`=4.
- x0 discard: `lsu_valid`=1, `lsu_rd`=0, `lsu_data`=0x1234 -> `lsu_ready`=1; next cycle `wen`=0; `wb_cnt` unchanged; a read of x0 returns 0.
- Debug priority: `dbg_wen`=1, `dbg_waddr`=7, `dbg_wdata`=0x55AA55AA with both sources valid -> both readys 0 that cycle; next cycle `wen`=1, `waddr`=7; the sources are served the cycle after debug drops, with order unchanged from before the debug cycle.
- Forwarding: EXU writes x3=0xCAFEF00D in cycle 0, and `fwd_raddr`=3 in cycle 1 -> `fwd_hit`=1, `fwd_data`=0xCAFEF00D; the same request in cycle 2 -> `fwd_hit`=0; `fwd_raddr`=0 in any cycle -> `fwd_hit`=0.
- Async reset mid-operation: pull `rst_n` low between edges while `wen`=1 -> `wen`=0 immediately, `wb_cnt`=0; the GPR target keeps its old value; after release, simultaneous requests grant LSU first.

Source files
------------

// File: rtl/gpr_wb_arb.sv
// gpr_wb_arb -- writeback arbiter for the single GPR file write port.
//
// Collects results from the EXU and LSU over valid/ready handshakes plus an
// unconditional debug write, picks one per cycle, and registers the winner
// for one cycle onto the GPR write port. While a write sits in that register
// the GPR array still holds the old value, so a forwarding lookup lets the
// decode-stage read see it. A retired-write counter feeds perf/difftest.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   exu_valid/exu_ready/exu_rd/exu_data   EXU result handshake
//   lsu_valid/lsu_ready/lsu_rd/lsu_data   LSU load result handshake
//   dbg_wen/dbg_waddr/dbg_wdata      debug write, no handshake, always wins
//   waddr/wdata/wen                  registered GPR write port
//   fwd_raddr/fwd_hit/fwd_data       forwarding lookup on the pending write
//   wb_cnt                           count of committed (non-x0) GPR writes
module gpr_wb_arb #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exu_valid,
  output logic            exu_ready,
  input  logic [AW-1:0]   exu_rd,
  input  logic [XLEN-1:0] exu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            dbg_wen,
  input  logic [AW-1:0]   dbg_waddr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic [AW-1:0]   waddr,
  output logic [XLEN-1:0] wdata,
  output logic            wen,
  input  logic [AW-1:0]   fwd_raddr,
  output logic            fwd_hit,
  output logic [XLEN-1:0] fwd_data,
  output logic [CNTW-1:0] wb_cnt
);

  typedef enum logic {
    SRC_EXU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  src_e            last_grant_q;
  src_e            last_grant_d;

  logic            grant_exu;
  logic            grant_lsu;
  logic            vld_p0;
  logic            wen_p0;
  logic [AW-1:0]   waddr_p0;
  logic [XLEN-1:0] wdata_p0;

  logic            vld_p1;
  logic [AW-1:0]   waddr_p1;
  logic [XLEN-1:0] wdata_p1;
  logic [CNTW-1:0] cnt_q;

  // ---- p0: arbitration and source select (combinational) ----
  // The round-robin pointer only moves when both sources contend; a lone
  // requester is served without disturbing the fairness order. Debug
  // stalls both sources and leaves the pointer untouched.
  always_comb begin
    grant_exu    = 1'b0;
    grant_lsu    = 1'b0;
    last_grant_d = last_grant_q;
    vld_p0       = 1'b0;
    waddr_p0     = '0;
    wdata_p0     = '0;

    if (dbg_wen) begin
      vld_p0   = 1'b1;
      waddr_p0 = dbg_waddr;
      wdata_p0 = dbg_wdata;
    end else if (exu_valid && lsu_valid) begin
      if (last_grant_q == SRC_EXU) begin
        grant_lsu    = 1'b1;
        last_grant_d = SRC_LSU;
      end else begin
        grant_exu    = 1'b1;
        last_grant_d = SRC_EXU;
      end
    end else if (exu_valid) begin
      grant_exu = 1'b1;
    end else if (lsu_valid) begin
      grant_lsu = 1'b1;
    end

    if (grant_exu) begin
      vld_p0   = 1'b1;
      waddr_p0 = exu_rd;
      wdata_p0 = exu_data;
    end else if (grant_lsu) begin
      vld_p0   = 1'b1;
      waddr_p0 = lsu_rd;
      wdata_p0 = lsu_data;
    end
  end

  // x0 is hardwired: the request is still accepted but never reaches the port.
  assign wen_p0    = vld_p0 && (waddr_p0 != '0);
  assign exu_ready = grant_exu;
  assign lsu_ready = grant_lsu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= SRC_EXU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  // ---- p1: registered GPR write port ----
  // Address/data follow every accepted request (including x0 discards) and
  // hold when idle; only the enable drops back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else begin
      vld_p1 <= wen_p0;
      if (vld_p0) begin
        waddr_p1 <= waddr_p0;
        wdata_p1 <= wdata_p0;
      end
    end
  end

  // ---- p2: commit into the GPR array, retired-write count ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (vld_p1) begin
      cnt_q <= cnt_q + CNTW'(1);
    end
  end

  assign wen    = vld_p1;
  assign waddr  = waddr_p1;
  assign wdata  = wdata_p1;
  assign wb_cnt = cnt_q;

  assign fwd_hit  = vld_p1 && (waddr_p1 == fwd_raddr) && (fwd_raddr != '0);
  assign fwd_data = fwd_hit ? wdata_p1 : '0;

endmodule

// File: tb/tb_gpr_wb_arb.sv
module tb_gpr_wb_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        exu_valid = 1'b0;
  logic        exu_ready;
  logic [4:0]  exu_rd = '0;
  logic [31:0] exu_data = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        dbg_wen = 1'b0;
  logic [4:0]  dbg_waddr = '0;
  logic [31:0] dbg_wdata = '0;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        wen;
  logic [4:0]  fwd_raddr = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [31:0] wb_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic chk_on = 1'b0;

  gpr_wb_arb dut (
    .clk(clk), .rst_n(rst_n),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .dbg_wen(dbg_wen), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata),
    .waddr(waddr), .wdata(wdata), .wen(wen),
    .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .wb_cnt(wb_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // GPR array target: captures whatever the DUT presents on the write port.
  logic [31:0] tb_gpr [32];
  logic        g_init = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (!g_init) begin
        for (int i = 0; i < 32; i++) tb_gpr[i] <= '0;
        g_init <= 1'b1;
      end
    end else if (wen) begin
      tb_gpr[waddr] <= wdata;
    end
  end

  // Reference model: who is served each cycle, what is pending on the port,
  // what the register file should contain and how many writes retired.
  logic        m_lsu_turn;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_cnt;
  logic [31:0] m_gpr [32];
  logic        m_init = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lsu_turn <= 1'b1;
      m_wen      <= 1'b0;
      m_waddr    <= '0;
      m_wdata    <= '0;
      m_cnt      <= '0;
      if (!m_init) begin
        for (int i = 0; i < 32; i++) m_gpr[i] <= '0;
        m_init <= 1'b1;
      end
    end else begin
      if (m_wen) begin
        m_gpr[m_waddr] <= m_wdata;
        m_cnt <= m_cnt + 1;
      end
      if (dbg_wen) begin
        m_wen <= (dbg_waddr != 0); m_waddr <= dbg_waddr; m_wdata <= dbg_wdata;
      end else if (exu_valid && lsu_valid) begin
        if (m_lsu_turn) begin
          m_wen <= (lsu_rd != 0); m_waddr <= lsu_rd; m_wdata <= lsu_data;
        end else begin
          m_wen <= (exu_rd != 0); m_waddr <= exu_rd; m_wdata <= exu_data;
        end
        m_lsu_turn <= !m_lsu_turn;
      end else if (exu_valid) begin
        m_wen <= (exu_rd != 0); m_waddr <= exu_rd; m_wdata <= exu_data;
      end else if (lsu_valid) begin
        m_wen <= (lsu_rd != 0); m_waddr <= lsu_rd; m_wdata <= lsu_data;
      end else begin
        m_wen <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      logic e_exu, e_lsu, e_hit;
      e_exu = !dbg_wen && exu_valid && (!lsu_valid || !m_lsu_turn);
      e_lsu = !dbg_wen && lsu_valid && (!exu_valid || m_lsu_turn);
      e_hit = m_wen && (m_waddr == fwd_raddr) && (fwd_raddr != 0);
      chk("m_exu_ready", exu_ready, e_exu);
      chk("m_lsu_ready", lsu_ready, e_lsu);
      chk("m_wen", wen, m_wen);
      if (m_wen) begin
        chk("m_waddr", waddr, m_waddr);
        chk("m_wdata", wdata, m_wdata);
      end
      chk("m_fwd_hit", fwd_hit, e_hit);
      chk("m_fwd_data", fwd_data, e_hit ? m_wdata : 32'h0);
      chk("m_wb_cnt", wb_cnt, m_cnt);
      chk("m_gpr_read", tb_gpr[fwd_raddr], m_gpr[fwd_raddr]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       exp_l [4];
    logic [4:0] exp_a [4];
    int ne, nl;
    exp_l = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_a = '{5'd2, 5'd1, 5'd2, 5'd1};
    ne = 0;
    nl = 0;

    // reset state
    #1 rst_n = 1'b0;
    #3;
    chk("rst_wen", wen, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wb_cnt", wb_cnt, 0);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    chk_on = 1'b1;

    // single EXU write
    tick();
    exu_valid = 1; exu_rd = 5; exu_data = 32'hDEADBEEF;
    #1 chk("t1_exu_ready", exu_ready, 1);
    tick();
    exu_valid = 0;
    chk("t1_wen", wen, 1);
    chk("t1_waddr", waddr, 5);
    chk("t1_wdata", wdata, 32'hDEADBEEF);
    tick();
    chk("t1_wb_cnt", wb_cnt, 1);
    chk("t1_gpr_x5", tb_gpr[5], 32'hDEADBEEF);

    // round-robin contention from the reset pointer
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k > 0) chk("t2_waddr", waddr, exp_a[k-1]);
      exu_valid = 1; exu_rd = 1; exu_data = 32'hE0000000 + ne;
      lsu_valid = 1; lsu_rd = 2; lsu_data = 32'hA0000000 + nl;
      #1;
      chk("t2_lsu_ready", lsu_ready, exp_l[k]);
      chk("t2_exu_ready", exu_ready, !exp_l[k]);
      if (exp_l[k]) nl++; else ne++;
    end
    tick();
    exu_valid = 0; lsu_valid = 0;
    chk("t2_waddr_last", waddr, 1);
    chk("t2_wdata_last", wdata, 32'hE0000001);
    tick();
    chk("t2_wb_cnt", wb_cnt, 4);

    // x0 discard
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h1234;
    #1 chk("t3_lsu_ready", lsu_ready, 1);
    tick();
    lsu_valid = 0;
    chk("t3_wen", wen, 0);
    tick();
    chk("t3_wb_cnt", wb_cnt, 4);
    chk("t3_gpr_x0", tb_gpr[0], 0);

    // debug priority with both sources waiting; LSU is next in order
    dbg_wen = 1; dbg_waddr = 7; dbg_wdata = 32'h55AA55AA;
    exu_valid = 1; exu_rd = 9;  exu_data = 32'h99999999;
    lsu_valid = 1; lsu_rd = 10; lsu_data = 32'hAAAAAAAA;
    #1;
    chk("t4_exu_ready", exu_ready, 0);
    chk("t4_lsu_ready", lsu_ready, 0);
    tick();
    dbg_wen = 0;
    chk("t4_wen", wen, 1);
    chk("t4_waddr", waddr, 7);
    chk("t4_wdata", wdata, 32'h55AA55AA);
    #1 chk("t4_lsu_first", lsu_ready, 1);
    tick();
    lsu_valid = 0;
    chk("t4_waddr_lsu", waddr, 10);
    #1 chk("t4_exu_next", exu_ready, 1);
    tick();
    exu_valid = 0;
    chk("t4_waddr_exu", waddr, 9);
    tick();

    // forwarding window
    exu_valid = 1; exu_rd = 3; exu_data = 32'hCAFEF00D; fwd_raddr = 3;
    #1 chk("t5_hit_c0", fwd_hit, 0);
    tick();
    exu_valid = 0;
    chk("t5_hit_c1", fwd_hit, 1);
    chk("t5_data_c1", fwd_data, 32'hCAFEF00D);
    fwd_raddr = 0;
    #1;
    chk("t5_hit_x0", fwd_hit, 0);
    chk("t5_data_x0", fwd_data, 0);
    fwd_raddr = 3;
    tick();
    chk("t5_hit_c2", fwd_hit, 0);
    chk("t5_gpr_x3", tb_gpr[3], 32'hCAFEF00D);

    // asynchronous reset while a write is pending
    exu_valid = 1; exu_rd = 5; exu_data = 32'h11112222;
    tick();
    exu_valid = 0;
    chk("t6_wen_before", wen, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_wen_rst", wen, 0);
    chk("t6_cnt_rst", wb_cnt, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    chk("t6_gpr_x5", tb_gpr[5], 32'hDEADBEEF);
    tick();
    exu_valid = 1; exu_rd = 1; exu_data = 32'h0000AAAA;
    lsu_valid = 1; lsu_rd = 2; lsu_data = 32'h0000BBBB;
    #1;
    chk("t6_lsu_first", lsu_ready, 1);
    chk("t6_exu_wait", exu_ready, 0);
    tick();
    lsu_valid = 0;
    #1 chk("t6_exu_second", exu_ready, 1);
    tick();
    exu_valid = 0;
    tick();
    tick();
    chk("t6_gpr_x2", tb_gpr[2], 32'h0000BBBB);
    chk("t6_wb_cnt", wb_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
